// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage feeding the IF/ID register. Owns the fetch PC,
//   issues word-aligned requests to instruction memory over a req/gnt/rvalid
//   handshake, and buffers returned words with their PCs in an in-order
//   prefetch FIFO. Presents one {pc, inst} pair per cycle, holds it under
//   stall, and flushes on redirect, dropping responses still in flight.
//
// Parameters
//   RESET_PC  first fetch address after reset
//   DEPTH     FIFO entries (power of two, >= 2); also caps buffered +
//             outstanding requests
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   stall               downstream hold, FIFO head not consumed
//   redirect            taken branch/jump, flushes the stage
//   redirect_pc         redirect target (bits [1:0] ignored)
//   imem_req/imem_addr  fetch request and word address
//   imem_gnt            memory accepted the request this cycle
//   imem_rvalid/rdata   in-order response
//   if_valid/if_pc/if_inst  FIFO head towards IF/ID (NOP when empty)
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);
    localparam logic [31:0]    NOP     = 32'h0000_0013;

    logic [31:0]      fetch_pc;
    logic [31:0]      resp_pc;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] discard;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    logic [31:0]      pc_mem   [DEPTH];
    logic [31:0]      inst_mem [DEPTH];

    logic [CNT_W:0]   occupancy;
    logic             req_fire;
    logic             push;
    logic             pop;
    logic [31:0]      target_pc;

    // Sequential PC step; wraps modulo 2^32.
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    always_comb begin
        // Credit check uses registered state only, so a pop or response in
        // this cycle does not open a slot until the next cycle.
        occupancy = {1'b0, count} + {1'b0, outstanding};
        imem_req  = !rst && !redirect && (occupancy < DEPTH_C);
        imem_addr = fetch_pc;
        req_fire  = imem_req && imem_gnt;
        push      = imem_rvalid && (discard == '0);
        pop       = if_valid && !stall;
        target_pc = redirect_pc & 32'hFFFF_FFFC;
    end

    assign if_valid = (count != '0);
    assign if_pc    = if_valid ? pc_mem[head]   : resp_pc;
    assign if_inst  = if_valid ? inst_mem[head] : NOP;

    // Control state: pointers, counters and PCs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            head        <= '0;
            tail        <= '0;
        end else if (redirect) begin
            // Everything still in flight, including a response landing now,
            // belongs to the old path and must be dropped on arrival.
            fetch_pc    <= target_pc;
            resp_pc     <= target_pc;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
            outstanding <= outstanding - CNT_W'(imem_rvalid);
            discard     <= outstanding - CNT_W'(imem_rvalid);
        end else begin
            if (req_fire) begin
                fetch_pc <= pc_next(fetch_pc);
            end
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(imem_rvalid);
            if (imem_rvalid && !push) begin
                discard <= discard - 1'b1;
            end
            if (push) begin
                resp_pc <= pc_next(resp_pc);
                tail    <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FIFO storage: data only, no reset needed since if_valid masks it.
    always_ff @(posedge clk) begin
        if (push && !redirect) begin
            pc_mem[tail]   <= resp_pc;
            inst_mem[tail] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    int checks = 0;
    int errors = 0;

    fetch_unit #(
        .RESET_PC (32'h0000_0100),
        .DEPTH    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_inst     (if_inst)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Instruction memory: in-order, fixed latency lat (>= 1 cycle after grant).
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t mq[$];
    int    edge_n = 0;
    int    lat = 1;
    int    m_inflight = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_inflight = 0;
            edge_n = 0;
            imem_rvalid <= 1'b0;
            imem_rdata  <= 32'h0;
        end else begin
            if (imem_rvalid) begin
                check("proto_rvalid_without_request", 32'(m_inflight > 0), 32'd1);
                m_inflight--;
            end
            if (imem_req && imem_gnt) begin
                mq.push_back('{addr: imem_addr, due: edge_n + lat - 1});
                m_inflight++;
            end
            if (mq.size() > 0 && mq[0].due <= edge_n) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= inst_of(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                imem_rvalid <= 1'b0;
            end
            edge_n++;
        end
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input int l, input logic g);
        @(negedge clk);
        rst      = 1'b1;
        stall    = 1'b0;
        redirect = 1'b0;
        imem_gnt = g;
        lat      = l;
        #1;
        check("rst_req",   32'(imem_req), 32'd0);
        check("rst_addr",  imem_addr,     32'h0000_0100);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_pc",    if_pc,         32'h0000_0100);
        check("rst_inst",  if_inst,       32'h0000_0013);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Stream from reset with a 1-cycle memory.
        do_reset(1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) nxt();
            check("stream_req",  32'(imem_req), 32'd1);
            check("stream_addr", imem_addr, 32'h100 + 32'(4 * i));
            if (i >= 2) begin
                check("stream_valid", 32'(if_valid), 32'd1);
                check("stream_pc",    if_pc, 32'h100 + 32'(4 * (i - 2)));
                check("stream_inst",  if_inst, inst_of(32'h100 + 32'(4 * (i - 2))));
            end else begin
                check("stream_empty", 32'(if_valid), 32'd0);
            end
        end

        // Back-pressure: head holds at 0x118 while the FIFO fills.
        for (int j = 0; j < 6; j++) begin
            nxt();
            if (j == 0) stall = 1'b1;
            check("stall_pc",   if_pc, 32'h118);
            check("stall_inst", if_inst, inst_of(32'h118));
            if (j >= 2) begin
                check("stall_req",  32'(imem_req), 32'd0);
                check("stall_addr", imem_addr, 32'h128);
            end
        end
        for (int j = 0; j < 8; j++) begin
            nxt();
            if (j == 0) stall = 1'b0;
            check("drain_valid", 32'(if_valid), 32'd1);
            check("drain_pc",    if_pc, 32'h118 + 32'(4 * j));
            check("drain_inst",  if_inst, inst_of(32'h118 + 32'(4 * j)));
        end

        // Redirect with two requests in flight, 3-cycle memory.
        do_reset(3, 1'b1);
        check("r2_addr0", imem_addr, 32'h100);
        nxt();
        check("r2_addr1", imem_addr, 32'h104);
        nxt();
        redirect = 1'b1;
        redirect_pc = 32'h0000_2002;
        #1;
        check("r2_req_blocked", 32'(imem_req), 32'd0);
        nxt();
        redirect = 1'b0;
        #1;
        check("r2_req",  32'(imem_req), 32'd1);
        check("r2_addr", imem_addr, 32'h2000);
        check("r2_inst_nop", if_inst, 32'h0000_0013);
        for (int j = 0; j < 4; j++) begin
            if (j > 0) nxt();
            check("r2_empty", 32'(if_valid), 32'd0);
        end
        for (int j = 0; j < 3; j++) begin
            nxt();
            check("r2_valid", 32'(if_valid), 32'd1);
            check("r2_pc",    if_pc, 32'h2000 + 32'(4 * j));
            check("r2_inst",  if_inst, inst_of(32'h2000 + 32'(4 * j)));
        end

        // Redirect in the same cycle as a response arrives.
        do_reset(3, 1'b1);
        nxt();
        nxt();
        check("rv_addr2", imem_addr, 32'h108);
        nxt();
        redirect = 1'b1;
        redirect_pc = 32'h0000_3000;
        #1;
        check("rv_req_blocked", 32'(imem_req), 32'd0);
        nxt();
        redirect = 1'b0;
        #1;
        check("rv_addr", imem_addr, 32'h3000);
        for (int j = 0; j < 4; j++) begin
            if (j > 0) nxt();
            check("rv_empty", 32'(if_valid), 32'd0);
        end
        for (int j = 0; j < 2; j++) begin
            nxt();
            check("rv_valid", 32'(if_valid), 32'd1);
            check("rv_pc",    if_pc, 32'h3000 + 32'(4 * j));
            check("rv_inst",  if_inst, inst_of(32'h3000 + 32'(4 * j)));
        end

        // Grant withheld for five cycles.
        do_reset(1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) nxt();
            check("gnt_req",   32'(imem_req), 32'd1);
            check("gnt_addr",  imem_addr, 32'h100);
            check("gnt_empty", 32'(if_valid), 32'd0);
        end
        nxt();
        imem_gnt = 1'b1;
        #1;
        check("gnt_addr_go", imem_addr, 32'h100);
        nxt();
        check("gnt_addr_next", imem_addr, 32'h104);
        nxt();
        check("gnt_valid", 32'(if_valid), 32'd1);
        check("gnt_pc",    if_pc, 32'h100);

        // Address wrap across 2^32.
        do_reset(1, 1'b1);
        nxt();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        #1;
        check("wrap_req_blocked", 32'(imem_req), 32'd0);
        nxt();
        redirect = 1'b0;
        #1;
        check("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
        nxt();
        check("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
        nxt();
        check("wrap_addr2", imem_addr, 32'h0000_0000);
        check("wrap_pc0",   if_pc, 32'hFFFF_FFF8);
        nxt();
        check("wrap_pc1",   if_pc, 32'hFFFF_FFFC);
        nxt();
        check("wrap_pc2",   if_pc, 32'h0000_0000);
        check("wrap_inst2", if_inst, inst_of(32'h0000_0000));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
